// File: rtl/subsample_8x8_pkg.sv
// Shared definitions for the 4:2:0 chroma subsampler: channel tags, widths and pixel type.
package subsample_8x8_pkg;
  localparam int unsigned CH        = 3;
  localparam int unsigned CH_W      = $clog2(CH + 1);
  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned IN_PIX    = 8;
  localparam int unsigned OUT_PIX   = 4;

  localparam logic [CH_W-1:0] CH_Y  = 2'b00;
  localparam logic [CH_W-1:0] CH_CB = 2'b01;
  localparam logic [CH_W-1:0] CH_CR = 2'b10;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/subsample_8x8_if.sv
// Row-beat handshake bundle: 8-pixel input rows in, 4-pixel averaged rows out.
interface subsample_8x8_if
  import subsample_8x8_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) ();
  logic [CH_W-1:0]                ch_in;
  logic                           valid_in;
  logic                           ready_in;
  logic [IN_PIX-1:0][PIX_W-1:0]   row_in;
  logic                           valid_out;
  logic                           ready_out;
  logic [OUT_PIX-1:0][PIX_W-1:0]  row_out;
  logic [CH_W-1:0]                ch_out;
  logic                           last_out;

  modport master (
    output ch_in, valid_in, row_in, ready_out,
    input  ready_in, valid_out, row_out, ch_out, last_out
  );

  modport slave (
    input  ch_in, valid_in, row_in, ready_out,
    output ready_in, valid_out, row_out, ch_out, last_out
  );
endinterface

// File: rtl/subsample_8x8_avg4.sv
// Combinational 2x2 average: stored horizontal pair sum plus two new pixels.
// SUBSAMPLE_ROUND_EN selects round-half-up; otherwise the average truncates.
module subsample_avg4
  import subsample_8x8_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W:0]   i_pair_sum,
  input  logic [PIX_W-1:0] i_pix_a,
  input  logic [PIX_W-1:0] i_pix_b,
  output logic [PIX_W-1:0] o_avg
);
  logic [PIX_W+1:0] w_sum;

  assign w_sum = {1'b0, i_pair_sum} + {2'b00, i_pix_a} + {2'b00, i_pix_b};

`ifdef SUBSAMPLE_ROUND_EN
  logic [PIX_W+1:0] w_rnd;
  // Max sum is 4*(2^PIX_W-1), so adding 2 cannot overflow PIX_W+2 bits.
  assign w_rnd = w_sum + (PIX_W+2)'(2);
  assign o_avg = PIX_W'(w_rnd >> 2);
`else
  assign o_avg = PIX_W'(w_sum >> 2);
`endif
endmodule

// File: rtl/subsample_8x8.sv
// 8x8 -> 4x4 chroma subsampler: even rows park pair sums, odd rows emit one averaged row.
// Averaging mode is set by SUBSAMPLE_ROUND_EN inside subsample_avg4.
module subsample_8x8
  import subsample_8x8_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  subsample_8x8_if.slave  bus
);
  logic [2:0]                     r_row_cnt;
  logic [CH_W-1:0]                r_ch;
  logic [CH_W-1:0]                r_ch_out;
  logic [OUT_PIX-1:0][PIX_W-1:0]  r_row_out;
  logic                           r_valid;
  logic                           r_last;
  logic                           w_accept;
  logic [OUT_PIX-1:0][PIX_W-1:0]  w_avg;

  // Only an odd row needs the output register, so only odd rows can stall.
  assign bus.ready_in  = !(r_row_cnt[0] && r_valid && !bus.ready_out);
  assign w_accept      = bus.valid_in && bus.ready_in;

  assign bus.valid_out = r_valid;
  assign bus.row_out   = r_row_out;
  assign bus.ch_out    = r_ch_out;
  assign bus.last_out  = r_last;

  generate
    for (genvar gi = 0; gi < OUT_PIX; gi++) begin : g_col
      logic [PIX_W:0] r_hbuf;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_hbuf <= '0;
        end else if (w_accept && !r_row_cnt[0]) begin
          r_hbuf <= {1'b0, bus.row_in[2*gi]} + {1'b0, bus.row_in[2*gi+1]};
        end
      end

      subsample_avg4 #(.PIX_W(PIX_W)) u_avg (
        .i_pair_sum (r_hbuf),
        .i_pix_a    (bus.row_in[2*gi]),
        .i_pix_b    (bus.row_in[2*gi+1]),
        .o_avg      (w_avg[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row_cnt <= 3'd0;
      r_ch      <= '0;
      r_ch_out  <= '0;
      r_row_out <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row_cnt <= r_row_cnt + 3'd1;
        if (r_row_cnt == 3'd0) begin
          r_ch <= bus.ch_in;
        end
      end
      // A reload on the draining edge takes priority, giving back-to-back output rows.
      if (w_accept && r_row_cnt[0]) begin
        r_row_out <= w_avg;
        r_valid   <= 1'b1;
        r_ch_out  <= r_ch;
        r_last    <= (r_row_cnt == 3'd7);
      end else if (r_valid && bus.ready_out) begin
        r_valid   <= 1'b0;
      end
    end
  end
endmodule
